// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes and the receive alignment FSM state.
package tmds_pkg;

   localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTL_TOKEN_11 = 10'b1010101011;

   typedef enum logic {
      SEARCH,
      LOCKED
   } align_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into control or video data.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] w,
   output logic       is_ctl,
   output logic [1:0] cd,
   output logic [7:0] vd
);

   logic [7:0] d;

   always_comb begin
      is_ctl = 1'b1;
      cd     = 2'b00;
      unique case (w)
         CTL_TOKEN_00: cd = 2'b00;
         CTL_TOKEN_01: cd = 2'b01;
         CTL_TOKEN_10: cd = 2'b10;
         CTL_TOKEN_11: cd = 2'b11;
         default:      is_ctl = 1'b0;
      endcase
   end

   // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
   always_comb begin
      d     = w[9] ? ~w[7:0] : w[7:0];
      vd    = 8'h00;
      vd[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         vd[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive decoder: bit-slip word alignment on control tokens, lock tracking, symbol decode.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int unsigned LOCK_COUNT    = 8,
   parameter int unsigned SEARCH_CYCLES = 4096,
   parameter int unsigned MAX_GAP       = 8192
) (
   input  logic       pixclk,
   input  logic       rst,
   input  logic [9:0] tmds_in,
   output logic [7:0] vd,
   output logic [1:0] cd,
   output logic       vde,
   output logic       locked,
   output logic [3:0] offset
);

   localparam int unsigned RunW   = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
   localparam int unsigned TimerW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
   localparam int unsigned GapW   = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

   localparam logic [RunW-1:0]   RunMax   = RunW'(LOCK_COUNT - 1);
   localparam logic [TimerW-1:0] TimerMax = TimerW'(SEARCH_CYCLES - 1);
   localparam logic [GapW-1:0]   GapMax   = GapW'(MAX_GAP - 1);

   align_state_t      state;
   logic [9:0]        r0, r1;
   logic [RunW-1:0]   run;
   logic [TimerW-1:0] timer;
   logic [GapW-1:0]   gap;

   logic [19:0] pair_shifted;
   logic [9:0]  w;
   logic        sym_is_ctl;
   logic [1:0]  sym_cd;
   logic [7:0]  sym_vd;

   logic go_lock, go_search, slip, hold_lock;

   // r1 is the older word, so it supplies the low (earlier) bits of the window.
   always_comb begin
      pair_shifted = {r0, r1} >> offset;
      w            = pair_shifted[9:0];
   end

   tmds_symbol_decode u_symbol_decode (
      .w      (w),
      .is_ctl (sym_is_ctl),
      .cd     (sym_cd),
      .vd     (sym_vd)
   );

   // Lock wins over a coincident search timeout.
   always_comb begin
      go_lock   = (state == SEARCH) && sym_is_ctl && (run == RunMax);
      go_search = (state == LOCKED) && !sym_is_ctl && (gap == GapMax);
      slip      = (state == SEARCH) && !go_lock && (timer == TimerMax);
      hold_lock = go_lock || ((state == LOCKED) && !go_search);
   end

   always_ff @(posedge pixclk or posedge rst) begin
      if (rst) begin
         state  <= SEARCH;
         r0     <= '0;
         r1     <= '0;
         run    <= '0;
         timer  <= '0;
         gap    <= '0;
         offset <= 4'd0;
         locked <= 1'b0;
         vd     <= 8'h00;
         cd     <= 2'b00;
         vde    <= 1'b0;
      end else begin
         r0 <= tmds_in;
         r1 <= r0;

         unique case (state)
            SEARCH: begin
               if (go_lock) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                  gap    <= '0;
                  run    <= '0;
                  timer  <= '0;
               end else if (slip) begin
                  offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                  run    <= '0;
                  timer  <= '0;
               end else begin
                  if (sym_is_ctl) begin
                     run <= (run == RunMax) ? run : run + 1'b1;
                  end else begin
                     run <= '0;
                  end
                  timer <= (timer == TimerMax) ? timer : timer + 1'b1;
               end
            end
            LOCKED: begin
               if (go_search) begin
                  state  <= SEARCH;
                  locked <= 1'b0;
                  run    <= '0;
                  timer  <= '0;
                  gap    <= '0;
               end else if (sym_is_ctl) begin
                  gap <= '0;
               end else begin
                  gap <= (gap == GapMax) ? gap : gap + 1'b1;
               end
            end
            default: state <= SEARCH;
         endcase

         // Outputs follow the lock status being entered on this edge.
         if (hold_lock) begin
            if (sym_is_ctl) begin
               vde <= 1'b0;
               cd  <= sym_cd;
            end else begin
               vde <= 1'b1;
               vd  <= sym_vd;
            end
         end else begin
            vde <= 1'b0;
            vd  <= 8'h00;
            cd  <= 2'b00;
         end
      end
   end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
Receive-side counterpart of the TMDS encoder. Takes raw 10-bit parallel words from the deserializer, which may be bit-misaligned. Finds symbol alignment by hunting for control tokens and tracks lock. Decodes each aligned symbol back to 8-bit video data, or to 2-bit control data plus video-data-enable, feeding the receive pixel pipeline.

Parameters:
LOCK_COUNT, 8, consecutive control tokens required at one offset to declare lock
SEARCH_CYCLES, 4096, cycles spent at one bit offset before slipping to the next
MAX_GAP, 8192, cycles without any control token while locked before lock is dropped

Ports:
pixclk  in  1  pixel clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
tmds_in  in  10  raw deserialized word; bit0 is the earliest serial bit
vd  out  8  decoded video data
cd  out  2  decoded control data {vsync,hsync}
vde  out  1  1 = current symbol is a data symbol
locked  out  1  alignment lock indicator
offset  out  4  current bit-slip offset, 0..9 (debug)

Behaviour:
- Reset, asynchronous: vd=0, cd=0, vde=0, locked=0, offset=0. FSM goes to SEARCH, all counters clear, word registers clear. Reset mid-operation aborts lock immediately.
- Word path:
  - r0 <= tmds_in; r1 <= r0.
  - Window w = ({r0,r1} >> offset)[9:0], where r1 holds the low bits. Offset 0 means w = r1.
  - Outputs are registered from w.
  - Latency: a word sampled at edge k reaches the outputs after edge k+2 at offset 0.
- Control token match, on w[9:0] written MSB first:
  - 1101010100 -> cd=00
  - 0010101011 -> cd=01
  - 0101010100 -> cd=10
  - 1010101011 -> cd=11
- Data decode, for any non-token w:
  - d = w[9] ? ~w[7:0] : w[7:0]
  - vd[0] = d[0]
  - For i = 1..7: vd[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
- Output rule while locked:
  - Token: vde=0, cd=decoded value, vd holds its previous value.
  - Non-token: vde=1, vd=decoded value, cd holds its previous value.
- Output rule while not locked: vde=0, vd=0, cd=0.
- FSM SEARCH:
  - run counts consecutive tokens and clears on any non-token.
  - timer increments every cycle.
  - run == LOCK_COUNT-1 and current w is a token -> LOCKED, locked=1 on the same edge, gap=0.
  - Otherwise, timer == SEARCH_CYCLES-1 -> offset = (offset==9) ? 0 : offset+1, and run and timer clear.
  - If lock and timeout coincide, lock wins.
- FSM LOCKED:
  - gap clears on any token and increments otherwise.
  - gap == MAX_GAP-1 with a non-token -> SEARCH, locked=0, offset kept, run, timer and gap clear.
- Counter widths are sized by $clog2 of their limit and saturate; they never wrap.
- The decoder does not check running disparity; it is meaningless to the decode.

Decomposition:
- Shared package tmds_pkg holds the four control-token constants (already used by the encoder) and the FSM state enum {SEARCH, LOCKED}.
- One natural sub-module, tmds_symbol_decode: purely combinational w -> {is_ctl, cd, vd}. It is reusable and unit-testable on its own.
- The alignment FSM, counters and barrel window stay in tmds_decoder.

Test Plan:
- Reset then an aligned stream of 10 x 1101010100 -> locked=1 after the 8th token reaches w, offset=0, cd=00, vde=0.
- Locked, then inputs 0100000000, 1000000000, 1011111111 -> after 2-cycle latency vd=0x00, 0xFF, 0xFE in order, with vde=1 on each.
- Stream rotated by 3 bits (serial order preserved), SEARCH_CYCLES=64, continuous 0010101011 tokens -> offset steps 0,1,2,3, locked asserts at offset 3, cd=01.
- Locked, MAX_GAP=32, then 32 consecutive data symbols -> locked drops after the 32nd, vde=0, offset unchanged. Next 8 tokens relock.
- Locked mid-data, then rst pulse for 1 cycle -> all outputs 0 asynchronously and offset=0; relocks normally after release.
- Token run of 7, one data word, then 8 tokens -> no lock on the first run; lock only after the 8th token of the second run.
